// File: rtl/regwb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package regwb_pkg;

  localparam int NREG = 32;
  localparam int RD_W = 5;
  localparam logic [RD_W-1:0] ZERO_REG = 5'd31;

  // Payload width carried by wb_entry_t; DATA_W of the arbiter must not exceed it.
  localparam int WB_DATA_W = 64;

  typedef struct packed {
    logic                 live;
    logic [RD_W-1:0]      rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // One-hot register select; the zero register never gets an update bit.
  function automatic logic [NREG-1:0] onehot32(input logic [RD_W-1:0] rd);
    logic [NREG-1:0] oh;
    oh = '0;
    if (rd != ZERO_REG) oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Holding FIFO for multi-cycle results. Each entry carries a live bit that is
// cleared when a newer pipeline write to the same register overtakes it; dead
// entries stay in order and are popped without producing a write.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [RD_W-1:0]   push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [RD_W-1:0]   kill_rd,
  output wb_entry_t         head,
  output logic              head_dead,
  output logic [CNT_W-1:0]  count,
  output logic [NREG-1:0]   pending
);

  logic [DEPTH-1:0]  live_q;
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  // Control state: kill matching entries, then retire the head, then append.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && live_q[i] && (rd_q[i] == kill_rd)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (push) begin
        live_q[tail_q] <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage is qualified by live_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= push_rd;
      data_q[tail_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign head_dead = (count_q != '0) && !live_q[head_q];

  // Head view; a popped slot always has its live bit cleared, so live implies occupied.
  always_comb begin
    head      = '0;
    head.live = live_q[head_q];
    head.rd   = rd_q[head_q];
    head.data = WB_DATA_W'(data_q[head_q]);
  end

  // Pending-write mask for the hazard unit, built from live entries only.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending = pending | onehot32(rd_q[i]);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x64 register array. The pipeline writeback (A)
// wins by default; buffered multi-cycle results (B) drain when A is idle, and a
// starvation FSM inserts a one-cycle pipeline stall to force the FIFO head out.
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [RD_W-1:0]   a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [RD_W-1:0]   b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic [NREG-1:0]   wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [NREG-1:0]   pending
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  wb_entry_t        head;
  logic             head_dead;
  logic [CNT_W-1:0] count;
  logic             grant_a;
  logic             grant_b;
  logic             deq;
  logic             enq_write;
  logic             kill_head;
  arb_state_t       state_q;
  arb_state_t       state_next;
  logic [SC_W-1:0]  starve_q;
  logic [SC_W-1:0]  starve_next;

  // Ready depends only on occupancy, so a full FIFO refuses even when it pops.
  assign b_ready = !reset && (count < CNT_FULL);

  // A forced drain blocks A for that cycle; otherwise A has priority.
  assign grant_a = a_valid && !stall;
  assign grant_b = head.live && (stall || !a_valid);

  // Dead heads retire silently alongside normal drains.
  assign deq = grant_b || head_dead;

  // Zero-register results and results already superseded by A are acknowledged but dropped.
  assign enq_write = b_valid && b_ready && (b_rd != ZERO_REG) &&
                     !(grant_a && (a_rd == b_rd));

  // A blocked head that A overwrites this cycle is about to die, so it is not starving.
  assign kill_head = grant_a && head.live && (head.rd == a_rd);

  regwb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (enq_write),
    .push_rd   (b_rd),
    .push_data (b_data),
    .pop       (deq),
    .kill_en   (grant_a),
    .kill_rd   (a_rd),
    .head      (head),
    .head_dead (head_dead),
    .count     (count),
    .pending   (pending)
  );

  // Starvation FSM: count consecutive blocked cycles of a live head, then force one drain.
  always_comb begin
    state_next  = state_q;
    starve_next = starve_q;
    case (state_q)
      IDLE, WAIT: begin
        if (count == '0) begin
          state_next  = IDLE;
          starve_next = '0;
        end else if (deq) begin
          starve_next = '0;
          if (head.live) state_next = WAIT;
        end else begin
          // Occupied, not dequeuing, no stall: the live head lost to A.
          state_next = WAIT;
          if (!kill_head) begin
            if (starve_q == SC_LAST) begin
              state_next  = FORCE;
              starve_next = '0;
            end else begin
              starve_next = starve_q + 1'b1;
            end
          end
        end
      end
      FORCE: begin
        starve_next = '0;
        state_next  = ((count == CNT_ONE) && !enq_write) ? IDLE : WAIT;
      end
      default: begin
        state_next  = IDLE;
        starve_next = '0;
      end
    endcase
  end

  // FSM state, stall flag and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      stall    <= 1'b0;
      wr_en    <= '0;
      wr_data  <= '0;
    end else begin
      state_q  <= state_next;
      starve_q <= starve_next;
      stall    <= (state_next == FORCE);
      if (grant_a) begin
        wr_en   <= onehot32(a_rd);
        wr_data <= a_data;
      end else if (grant_b) begin
        wr_en   <= onehot32(head.rd);
        wr_data <= head.data[DATA_W-1:0];
      end else begin
        wr_en   <= '0;
      end
    end
  end

endmodule
